muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 42 ++++
 rtl/muldiv_divider.sv | 52 +++++
 rtl/muldiv_unit.sv | 169 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: op encodings,
// FSM state encoding, default widths and operand signedness helpers.
// Optional divider build: define MULDIV_DIV_EN.
package muldiv_pkg;

    localparam int unsigned XLEN_DEFAULT        = 32;
    localparam int unsigned REG_SEL_LEN_DEFAULT = 5;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // rs1 is treated as signed by these ops
    function automatic logic op_src_one_signed(input logic [2:0] op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM:  return 1'b1;
            OP_MUL, OP_MULHU, OP_DIVU, OP_REMU:  return 1'b0;
            default:                             return 1'b0;
        endcase
    endfunction

    // rs2 is treated as signed by these ops
    function automatic logic op_src_two_signed(input logic [2:0] op);
        case (op)
            OP_MULH, OP_DIV, OP_REM:                        return 1'b1;
            OP_MUL, OP_MULHSU, OP_MULHU, OP_DIVU, OP_REMU:  return 1'b0;
            default:                                        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_divider.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per
// step. The parent counter drives step/first; on the first step the
// dividend is taken straight from the input instead of the register.
module muldiv_divider
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            step,
    input  logic            first,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] quotient_c,
    output logic [XLEN-1:0] remainder_c
);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quo_cur;
    logic [XLEN-1:0] rem_cur;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;

    // One restoring step: shift in the next dividend bit, trial-subtract
    always_comb begin
        quo_cur = first ? dividend : quo_q;
        rem_cur = first ? '0 : rem_q;
        shifted = {rem_cur, quo_cur[XLEN-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[XLEN]) begin
            remainder_c = diff[XLEN-1:0];
            quotient_c  = {quo_cur[XLEN-2:0], 1'b1};
        end else begin
            remainder_c = shifted[XLEN-1:0];
            quotient_c  = {quo_cur[XLEN-2:0], 1'b0};
        end
    end

    // Partial quotient/remainder registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo_q <= '0;
            rem_q <= '0;
        end else if (step) begin
            quo_q <= quotient_c;
            rem_q <= remainder_c;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: IDLE -> CALC (XLEN cycles) -> DONE.
// Define MULDIV_DIV_EN to include the divider; without it op[2]=1 completes
// one cycle after start with illegal set and no writeback.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN        = XLEN_DEFAULT,
    parameter int unsigned REG_SEL_LEN = REG_SEL_LEN_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2:0]             op,
    input  logic [XLEN-1:0]        src_one,
    input  logic [XLEN-1:0]        src_two,
    input  logic [REG_SEL_LEN-1:0] dest,
    output logic                   busy,
    output logic                   done,
    output logic                   illegal,
    output logic                   wb_enable,
    output logic [REG_SEL_LEN-1:0] wb_dest,
    output logic [XLEN-1:0]        wb_data
);

    localparam int unsigned     CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e                 state;
    logic [CNT_W-1:0]       cnt;
    logic [2:0]             op_q;
    logic [XLEN-1:0]        src_one_q;
    logic [XLEN-1:0]        src_two_q;
    logic [REG_SEL_LEN-1:0] dest_q;
    logic [2*XLEN-1:0]      prod;

    logic                   one_neg_c;
    logic                   two_neg_c;
    logic [XLEN-1:0]        one_mag_c;
    logic [XLEN-1:0]        two_mag_c;
    logic [XLEN-1:0]        mul_lo_c;
    logic [XLEN-1:0]        mul_hi_c;
    logic [XLEN:0]          mul_sum_c;
    logic [2*XLEN-1:0]      prod_next_c;
    logic [2*XLEN-1:0]      prod_fixed_c;
    logic [XLEN-1:0]        mul_result_c;
    logic [XLEN-1:0]        result_c;
    logic                   illegal_op_c;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    // Shift-add multiply step on magnitudes; sign fix applied to the final product
    always_comb begin
        one_neg_c    = op_src_one_signed(op_q) & src_one_q[XLEN-1];
        two_neg_c    = op_src_two_signed(op_q) & src_two_q[XLEN-1];
        one_mag_c    = magnitude(src_one_q, one_neg_c);
        two_mag_c    = magnitude(src_two_q, two_neg_c);
        mul_lo_c     = (cnt == '0) ? two_mag_c : prod[XLEN-1:0];
        mul_hi_c     = (cnt == '0) ? '0 : prod[2*XLEN-1:XLEN];
        mul_sum_c    = {1'b0, mul_hi_c} + (mul_lo_c[0] ? {1'b0, one_mag_c} : '0);
        prod_next_c  = {mul_sum_c, mul_lo_c[XLEN-1:1]};
        prod_fixed_c = (one_neg_c ^ two_neg_c) ? -prod_next_c : prod_next_c;
        mul_result_c = (op_q == OP_MUL) ? prod_fixed_c[XLEN-1:0]
                                        : prod_fixed_c[2*XLEN-1:XLEN];
    end

`ifdef MULDIV_DIV_EN
    logic [XLEN-1:0] quo_c;
    logic [XLEN-1:0] rem_c;
    logic [XLEN-1:0] quot_fixed_c;
    logic [XLEN-1:0] rem_fixed_c;
    logic            div_zero_c;

    muldiv_divider #(
        .XLEN (XLEN)
    ) u_divider (
        .clk         (clk),
        .reset       (reset),
        .step        (state == S_CALC),
        .first       (cnt == '0),
        .dividend    (one_mag_c),
        .divisor     (two_mag_c),
        .quotient_c  (quo_c),
        .remainder_c (rem_c)
    );

    // Divide-by-zero overrides; quotient/remainder sign correction
    always_comb begin
        div_zero_c   = (src_two_q == '0);
        quot_fixed_c = div_zero_c ? '1
                     : ((one_neg_c ^ two_neg_c) ? -quo_c : quo_c);
        rem_fixed_c  = div_zero_c ? src_one_q
                     : (one_neg_c ? -rem_c : rem_c);
        result_c     = op_q[2] ? (op_q[1] ? rem_fixed_c : quot_fixed_c) : mul_result_c;
    end

    assign illegal_op_c = 1'b0;
`else
    assign result_c     = mul_result_c;
    assign illegal_op_c = op[2];
`endif

    // Control FSM with registered status and writeback outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_q      <= '0;
            src_one_q <= '0;
            src_two_q <= '0;
            dest_q    <= '0;
            prod      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            illegal   <= 1'b0;
            wb_enable <= 1'b0;
            wb_dest   <= '0;
            wb_data   <= '0;
        end else begin
            done      <= 1'b0;
            illegal   <= 1'b0;
            wb_enable <= 1'b0;
            wb_dest   <= '0;
            wb_data   <= '0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        src_one_q <= src_one;
                        src_two_q <= src_two;
                        dest_q    <= dest;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        if (illegal_op_c) begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            illegal <= 1'b1;
                            wb_dest <= dest;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    prod <= prod_next_c;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        wb_enable <= (dest_q != '0);
                        wb_dest   <= dest_q;
                        wb_data   <= result_c;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an arithmetic reference model and a
// per-cycle output checker. Expectations follow MULDIV_DIV_EN when defined.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_DIV_EN
    localparam bit DIV_ON = 1'b1;
`else
    localparam bit DIV_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] src_one = '0;
    logic [31:0] src_two = '0;
    logic [4:0]  dest = '0;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        wb_enable;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model of the single in-flight operation
    int          m_start = -100;
    int          m_done  = -100;
    logic        m_ill   = 1'b0;
    logic        m_en    = 1'b0;
    logic [4:0]  m_dest  = '0;
    logic [31:0] m_data  = '0;

    muldiv_unit dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .src_one   (src_one),
        .src_two   (src_two),
        .dest      (dest),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal),
        .wb_enable (wb_enable),
        .wb_dest   (wb_dest),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result from plain 64-bit arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sp;
        logic [63:0] up;
        if (o[2] && !DIV_ON) return 32'h0;
        case (o)
            OP_MUL: begin
                up = {32'h0, a} * {32'h0, b};
                return up[31:0];
            end
            OP_MULH: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                return sp[63:32];
            end
            OP_MULHSU: begin
                sp = longint'($signed(a)) * longint'({32'h0, b});
                return sp[63:32];
            end
            OP_MULHU: begin
                up = {32'h0, a} * {32'h0, b};
                return up[63:32];
            end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'($signed(a) / $signed(b));
            end
            OP_DIVU:
                return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'($signed(a) % $signed(b));
            end
            default:
                return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Every cycle: status and writeback outputs against the model
    always @(negedge clk) begin
        chk("busy", {63'h0, busy}, {63'h0, (cyc > m_start && cyc <= m_done)});
        if (cyc == m_done) begin
            chk("done", {63'h0, done}, 64'h1);
            chk("illegal", {63'h0, illegal}, {63'h0, m_ill});
            chk("wb_enable", {63'h0, wb_enable}, {63'h0, m_en});
            chk("wb_dest", {59'h0, wb_dest}, {59'h0, m_dest});
            chk("wb_data", {32'h0, wb_data}, {32'h0, m_data});
        end else begin
            chk("quiet_outputs", {25'h0, done, wb_enable, wb_dest, wb_data}, 64'h0);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, output int s, output bit acc);
        @(negedge clk);
        #1;
        start   = 1'b1;
        op      = o;
        src_one = a;
        src_two = b;
        dest    = d;
        s       = cyc;
        acc     = (cyc > m_done);
        if (acc) begin
            m_start = cyc;
            m_ill   = o[2] && !DIV_ON;
            m_done  = cyc + (m_ill ? 1 : 33);
            m_data  = ref_result(o, a, b);
            m_en    = !m_ill && (d != 0);
            m_dest  = d;
        end
        @(posedge clk);
        #1;
        start   = 1'b0;
        op      = 3'($urandom);
        src_one = $urandom;
        src_two = $urandom;
        dest    = 5'($urandom);
    endtask

    task automatic wait_done(output int dc, output bit ok);
        ok = 1'b0;
        dc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                dc = cyc;
                break;
            end
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic [31:0] lit);
        int          s;
        int          dc;
        bit          ok;
        bit          acc;
        bit          ill;
        logic [31:0] want;
        ill  = o[2] && !DIV_ON;
        want = ill ? 32'h0 : lit;
        issue(o, a, b, d, s, acc);
        chk({nm, "_accepted"}, {63'h0, acc}, 64'h1);
        chk({nm, "_model"}, {32'h0, m_data}, {32'h0, want});
        wait_done(dc, ok);
        if (!ok) begin
            chk({nm, "_timeout"}, 64'h0, 64'h1);
        end else begin
            chk({nm, "_latency"}, 64'(dc - s), ill ? 64'd1 : 64'd33);
            chk({nm, "_data"}, {32'h0, wb_data}, {32'h0, want});
            chk({nm, "_illegal"}, {63'h0, illegal}, {63'h0, ill});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        int s2;
        int pulses;
        bit acc;

        repeat (3) @(negedge clk);
        chk("reset_state", {58'h0, busy, done, illegal, wb_enable, |wb_dest, |wb_data}, 64'h0);
        #1;
        reset = 1'b1;

        run_op("mul_7_m3",    OP_MUL,    32'd7,        32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB);
        run_op("mulhu_max",   OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE);
        run_op("mulhsu_m1",   OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF);
        run_op("mulh_min",    OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd3,  32'h4000_0000);
        run_op("mulh_m1m1",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0);
        run_op("mulhu_2",     OP_MULHU,  32'h8000_0000, 32'd2,         5'd6,  32'h1);
        run_op("mul_wrap",    OP_MUL,    32'h0001_0000, 32'h0001_0000, 5'd7,  32'h0);
        run_op("mulh_neg",    OP_MULH,   32'd7,        32'hFFFF_FFFD, 5'd8,  32'hFFFF_FFFF);
        run_op("mul_shift",   OP_MUL,    32'h1234_5678, 32'h10,        5'd9,  32'h2345_6780);
        run_op("mulhsu_pos",  OP_MULHSU, 32'd2,        32'h8000_0000, 5'd10, 32'h1);
        run_op("mulhsu_neg",  OP_MULHSU, 32'hFFFF_FFFE, 32'h8000_0000, 5'd11, 32'hFFFF_FFFF);

        run_op("div_m7_2",    OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd12, 32'hFFFF_FFFD);
        run_op("rem_m7_2",    OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd13, 32'hFFFF_FFFF);
        run_op("divu_5_0",    OP_DIVU,   32'd5,        32'd0,         5'd14, 32'hFFFF_FFFF);
        run_op("remu_5_0",    OP_REMU,   32'd5,        32'd0,         5'd15, 32'd5);
        run_op("div_ovf",     OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000);
        run_op("rem_ovf",     OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0);
        run_op("div_7_m2",    OP_DIV,    32'd7,        32'hFFFF_FFFE, 5'd18, 32'hFFFF_FFFD);
        run_op("rem_7_m2",    OP_REM,    32'd7,        32'hFFFF_FFFE, 5'd19, 32'd1);
        run_op("divu_100_7",  OP_DIVU,   32'd100,      32'd7,         5'd20, 32'd14);
        run_op("remu_100_7",  OP_REMU,   32'd100,      32'd7,         5'd21, 32'd2);
        run_op("div_m5_0",    OP_DIV,    32'hFFFF_FFFB, 32'd0,         5'd22, 32'hFFFF_FFFF);
        run_op("rem_m5_0",    OP_REM,    32'hFFFF_FFFB, 32'd0,         5'd23, 32'hFFFF_FFFB);
        run_op("divu_bigdiv", OP_DIVU,   32'hFFFF_FFFF, 32'h8000_0001, 5'd24, 32'd1);
        run_op("remu_bigdiv", OP_REMU,   32'hFFFF_FFFF, 32'h8000_0001, 5'd25, 32'h7FFF_FFFE);

        // dest=0 suppresses writeback; a start while busy is dropped
        issue(OP_MUL, 32'd3, 32'd4, 5'd0, s, acc);
        chk("dest0_accepted", {63'h0, acc}, 64'h1);
        chk("dest0_model", {32'h0, m_data}, 64'd12);
        while (cyc < s + 4) @(negedge clk);
        issue(OP_MUL, 32'd9, 32'd9, 5'd3, s2, acc);
        chk("busy_start_ignored", {63'h0, acc}, 64'h0);
        chk("busy_start_cycle", 64'(s2 - s), 64'd5);
        pulses = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                chk("dest0_data", {32'h0, wb_data}, 64'd12);
            end
        end
        chk("single_done_pulse", 64'(pulses), 64'd1);

        // Reset mid-operation aborts with no writeback
        issue(OP_MUL, 32'd3, 32'd4, 5'd5, s, acc);
        chk("abort_accepted", {63'h0, acc}, 64'h1);
        while (cyc < s + 10) @(negedge clk);
        chk("abort_busy_before", {63'h0, busy}, 64'h1);
        #1;
        reset   = 1'b0;
        m_start = -100;
        m_done  = -100;
        #1;
        chk("abort_busy_async", {63'h0, busy}, 64'h0);
        chk("abort_outputs_async", {58'h0, done, illegal, wb_enable, |wb_dest, |wb_data, 1'b0}, 64'h0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        run_op("after_reset", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);
        run_op("back_to_back", OP_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd31, 32'h1);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
